axi_tlb_lookup: RTL and testbench

// - Address-translation lookup stage feeding the AXI TLB join/demux: one write and one read lookup pipe.
// - Each pipe accepts an Ax address and returns {hit, translated addr} one cycle later over valid/ready.
// - Results are consumed in order alongside the forked Ax beat; write and read pipes are fully independent.

---
 rtl/axi_tlb_pkg.sv | 17 +
 rtl/axi_tlb_lookup_chan.sv | 124 ++++++++++++
 rtl/axi_tlb_lookup.sv | 85 ++++++++
 tb/tb_axi_tlb_lookup.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_tlb_pkg.sv
// Shared constants and page arithmetic for the AXI TLB lookup pipes.
package axi_tlb_pkg;

    localparam int PageOffsetWidth = 12;
    localparam int MaxPageWidth    = 64;

    // Page numbers are carried at a fixed wide width; callers truncate,
    // so the result wraps modulo the caller's page-number width.
    function automatic logic [MaxPageWidth-1:0] page_translate(
        input logic [MaxPageWidth-1:0] first,
        input logic [MaxPageWidth-1:0] base,
        input logic [MaxPageWidth-1:0] page
    );
        return base + (page - first);
    endfunction

endpackage

// File: rtl/axi_tlb_lookup_chan.sv
// One lookup pipe: range match, lowest-index priority and a 1-deep result register.
// Optional multi-hit reporting under AXI_TLB_LOOKUP_MULTIHIT_EN.
module axi_tlb_lookup_chan
    import axi_tlb_pkg::*;
#(
    parameter int  InpAddrWidth  = 32,
    parameter int  OupAddrWidth  = 48,
    parameter int  NumEntries    = 4,
    parameter bit  ReadOnlyCheck = 1'b0,
    parameter type res_t         = logic [OupAddrWidth:0],
    parameter type entry_t       = logic [2*(InpAddrWidth-12)+(OupAddrWidth-12)+1:0]
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [InpAddrWidth-1:0]      req_addr_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    output res_t                         res_o,
    output logic                         res_valid_o,
    input  logic                         res_ready_i,
`ifdef AXI_TLB_LOOKUP_MULTIHIT_EN
    output logic                         multihit_o,
`endif
    input  entry_t [NumEntries-1:0]      entries_i,
    input  logic                         bypass_i
);

    localparam int PageWidth = InpAddrWidth - PageOffsetWidth;
    localparam int BaseWidth = OupAddrWidth - PageOffsetWidth;

    typedef struct packed {
        logic [PageWidth-1:0] first;
        logic [PageWidth-1:0] last;
        logic [BaseWidth-1:0] base;
        logic                 read_only;
        logic                 valid;
    } entry_s;

    typedef struct packed {
        logic                    hit;
        logic [OupAddrWidth-1:0] addr;
    } res_s;

    logic [PageWidth-1:0]  page;
    logic [NumEntries-1:0] match;
    entry_s                ent [NumEntries];
    logic [PageWidth-1:0]  sel_first;
    logic [BaseWidth-1:0]  sel_base;
    logic [BaseWidth-1:0]  xlat_page;
    logic                  found;
    logic                  force_miss;
    logic                  full_q;
    logic                  req_fire;
    res_s                  res_d, res_q;

    assign page = req_addr_i[InpAddrWidth-1:PageOffsetWidth];

    for (genvar i = 0; i < NumEntries; i++) begin : g_match
        assign ent[i]   = entry_s'(entries_i[i]);
        assign match[i] = ent[i].valid && !(ReadOnlyCheck && ent[i].read_only) &&
                          (ent[i].first <= page) && (page <= ent[i].last);
    end

`ifdef AXI_TLB_LOOKUP_MULTIHIT_EN
    logic multi;
    logic multi_q;
    // More than one bit set iff clearing the lowest set bit leaves something.
    assign multi      = |(match & (match - NumEntries'(1)));
    assign force_miss = multi;
`else
    assign force_miss = 1'b0;
`endif

    always_comb begin
        sel_first = '0;
        sel_base  = '0;
        found     = 1'b0;
        for (int i = 0; i < NumEntries; i++) begin
            if (match[i] && !found) begin
                sel_first = ent[i].first;
                sel_base  = ent[i].base;
                found     = 1'b1;
            end
        end
        xlat_page = BaseWidth'(page_translate(MaxPageWidth'(sel_first),
                                              MaxPageWidth'(sel_base),
                                              MaxPageWidth'(page)));
        res_d = '0;
        if (bypass_i) begin
            res_d.hit  = 1'b1;
            res_d.addr = OupAddrWidth'(req_addr_i);
        end else if (found && !force_miss) begin
            res_d.hit  = 1'b1;
            res_d.addr = {xlat_page, req_addr_i[PageOffsetWidth-1:0]};
        end
    end

    assign req_ready_o = !full_q || res_ready_i;
    assign req_fire    = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            res_q  <= '0;
        end else if (req_fire) begin
            full_q <= 1'b1;
            res_q  <= res_d;
        end else if (res_ready_i) begin
            full_q <= 1'b0;
        end
    end

`ifdef AXI_TLB_LOOKUP_MULTIHIT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       multi_q <= 1'b0;
        else if (req_fire) multi_q <= multi && !bypass_i;
    end
    assign multihit_o = full_q && multi_q;
`endif

    assign res_valid_o = full_q;
    assign res_o       = res_t'(res_q);

endmodule

// File: rtl/axi_tlb_lookup.sv
// Write and read address-translation lookup pipes for the AXI TLB.
// Define AXI_TLB_LOOKUP_MULTIHIT_EN to add wr_multihit_o/rd_multihit_o.
module axi_tlb_lookup
    import axi_tlb_pkg::*;
#(
    parameter int  InpAddrWidth = 32,
    parameter int  OupAddrWidth = 48,
    parameter int  NumEntries   = 4,
    parameter type res_t        = logic [OupAddrWidth:0],
    parameter type entry_t      = logic [2*(InpAddrWidth-12)+(OupAddrWidth-12)+1:0]
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    test_en_i,
    input  logic [InpAddrWidth-1:0] wr_req_addr_i,
    input  logic                    wr_req_valid_i,
    output logic                    wr_req_ready_o,
    output res_t                    wr_res_o,
    output logic                    wr_res_valid_o,
    input  logic                    wr_res_ready_i,
    input  logic [InpAddrWidth-1:0] rd_req_addr_i,
    input  logic                    rd_req_valid_i,
    output logic                    rd_req_ready_o,
    output res_t                    rd_res_o,
    output logic                    rd_res_valid_o,
    input  logic                    rd_res_ready_i,
`ifdef AXI_TLB_LOOKUP_MULTIHIT_EN
    output logic                    wr_multihit_o,
    output logic                    rd_multihit_o,
`endif
    input  entry_t [NumEntries-1:0] entries_i,
    input  logic                    bypass_i
);

    logic unused_test_en;
    assign unused_test_en = test_en_i;

    // Writes must not land on read-only pages; reads may.
    axi_tlb_lookup_chan #(
        .InpAddrWidth (InpAddrWidth),
        .OupAddrWidth (OupAddrWidth),
        .NumEntries   (NumEntries),
        .ReadOnlyCheck(1'b1),
        .res_t        (res_t),
        .entry_t      (entry_t)
    ) i_wr (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_addr_i (wr_req_addr_i),
        .req_valid_i(wr_req_valid_i),
        .req_ready_o(wr_req_ready_o),
        .res_o      (wr_res_o),
        .res_valid_o(wr_res_valid_o),
        .res_ready_i(wr_res_ready_i),
`ifdef AXI_TLB_LOOKUP_MULTIHIT_EN
        .multihit_o (wr_multihit_o),
`endif
        .entries_i  (entries_i),
        .bypass_i   (bypass_i)
    );

    axi_tlb_lookup_chan #(
        .InpAddrWidth (InpAddrWidth),
        .OupAddrWidth (OupAddrWidth),
        .NumEntries   (NumEntries),
        .ReadOnlyCheck(1'b0),
        .res_t        (res_t),
        .entry_t      (entry_t)
    ) i_rd (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_addr_i (rd_req_addr_i),
        .req_valid_i(rd_req_valid_i),
        .req_ready_o(rd_req_ready_o),
        .res_o      (rd_res_o),
        .res_valid_o(rd_res_valid_o),
        .res_ready_i(rd_res_ready_i),
`ifdef AXI_TLB_LOOKUP_MULTIHIT_EN
        .multihit_o (rd_multihit_o),
`endif
        .entries_i  (entries_i),
        .bypass_i   (bypass_i)
    );

endmodule

// File: tb/tb_axi_tlb_lookup.sv
// Directed and randomized bench for axi_tlb_lookup against a behavioural model.
module tb_axi_tlb_lookup;

    localparam int IW = 32;
    localparam int OW = 48;
    localparam int NE = 4;

    typedef struct packed {
        logic          hit;
        logic [OW-1:0] addr;
    } res_s;

    typedef struct packed {
        logic [19:0] first;
        logic [19:0] last;
        logic [35:0] base;
        logic        read_only;
        logic        valid;
    } entry_s;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic test_en = 1'b0;
    logic [IW-1:0] wr_addr, rd_addr;
    logic wr_v, rd_v, wr_rdy, rd_rdy, wr_rv, rd_rv, wr_rr, rd_rr;
    res_s wr_res, rd_res;
    entry_s [NE-1:0] ents;
    logic bypass;
`ifdef AXI_TLB_LOOKUP_MULTIHIT_EN
    logic wr_mh, rd_mh;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_tlb_lookup #(
        .InpAddrWidth(IW),
        .OupAddrWidth(OW),
        .NumEntries  (NE),
        .res_t       (res_s),
        .entry_t     (entry_s)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .test_en_i     (test_en),
        .wr_req_addr_i (wr_addr),
        .wr_req_valid_i(wr_v),
        .wr_req_ready_o(wr_rdy),
        .wr_res_o      (wr_res),
        .wr_res_valid_o(wr_rv),
        .wr_res_ready_i(wr_rr),
        .rd_req_addr_i (rd_addr),
        .rd_req_valid_i(rd_v),
        .rd_req_ready_o(rd_rdy),
        .rd_res_o      (rd_res),
        .rd_res_valid_o(rd_rv),
        .rd_res_ready_i(rd_rr),
`ifdef AXI_TLB_LOOKUP_MULTIHIT_EN
        .wr_multihit_o (wr_mh),
        .rd_multihit_o (rd_mh),
`endif
        .entries_i     (ents),
        .bypass_i      (bypass)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic res_s mk(input logic h, input logic [OW-1:0] a);
        res_s r;
        r.hit  = h;
        r.addr = a;
        return r;
    endfunction

    // Number of table entries whose page range covers the address.
    function automatic int count_hits(input logic [IW-1:0] a, input bit is_wr, input entry_s [NE-1:0] e);
        longint pg = longint'(a >> 12);
        int n = 0;
        for (int i = 0; i < NE; i++)
            if (e[i].valid && !(is_wr && e[i].read_only) &&
                pg >= longint'(e[i].first) && pg <= longint'(e[i].last)) n++;
        return n;
    endfunction

    function automatic res_s ref_lookup(input logic [IW-1:0] a, input bit is_wr,
                                        input entry_s [NE-1:0] e, input logic byp);
        longint pg = longint'(a >> 12);
        res_s r = '0;
        if (byp) return mk(1'b1, OW'(a));
`ifdef AXI_TLB_LOOKUP_MULTIHIT_EN
        if (count_hits(a, is_wr, e) > 1) return r;
`endif
        for (int i = NE - 1; i >= 0; i--)
            if (e[i].valid && !(is_wr && e[i].read_only) &&
                pg >= longint'(e[i].first) && pg <= longint'(e[i].last))
                r = mk(1'b1, {36'(longint'(e[i].base) + pg - longint'(e[i].first)), a[11:0]});
        return r;
    endfunction

    task automatic lookup(input bit is_wr, input logic [IW-1:0] a, input string tag, input res_s exp);
        if (is_wr) begin wr_addr = a; wr_v = 1'b1; wr_rr = 1'b1; end
        else       begin rd_addr = a; rd_v = 1'b1; rd_rr = 1'b1; end
        @(posedge clk); #1;
        wr_v = 1'b0;
        rd_v = 1'b0;
        check({tag, "_vld"}, is_wr ? wr_rv : rd_rv, 64'd1);
        check(tag, is_wr ? wr_res : rd_res, exp);
        check({tag, "_ref"}, is_wr ? wr_res : rd_res, ref_lookup(a, is_wr, ents, bypass));
`ifdef AXI_TLB_LOOKUP_MULTIHIT_EN
        check({tag, "_mh"}, is_wr ? wr_mh : rd_mh, (count_hits(a, is_wr, ents) > 1) && !bypass);
`endif
        @(posedge clk); #1;
    endtask

    bit   ewf, erf;
    res_s ewr, err;
`ifdef AXI_TLB_LOOKUP_MULTIHIT_EN
    bit   ewm, erm;
`endif

    initial begin
        wr_addr = '0; rd_addr = '0; wr_v = 0; rd_v = 0; wr_rr = 0; rd_rr = 0;
        ents = '0; bypass = 0;
        #2;
        check("rst_wr_vld", wr_rv, 0);
        check("rst_rd_vld", rd_rv, 0);
        check("rst_wr_res", wr_res, 0);
        check("rst_rd_res", rd_res, 0);
        check("rst_wr_rdy", wr_rdy, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        ents[0] = '{first: 20'h10, last: 20'h1F, base: 36'h80, read_only: 1'b0, valid: 1'b1};
        lookup(0, 32'h0001_2345, "hit_rd", mk(1, 48'h0000_0008_2345));
        lookup(1, 32'h0001_2345, "hit_wr", mk(1, 48'h0000_0008_2345));
        lookup(0, 32'h0001_FFFF, "last_rd", mk(1, 48'h0000_0008_FFFF));
        lookup(0, 32'h0000_FFFF, "below_rd", mk(0, 48'h0));

        ents[0].read_only = 1'b1;
        lookup(1, 32'h0001_0000, "ro_wr", mk(0, 48'h0));
        lookup(0, 32'h0001_0000, "ro_rd", mk(1, 48'h0000_0008_0000));
        ents[0].read_only = 1'b0;

        ents[1] = '{first: 20'h10, last: 20'h10, base: 36'h90, read_only: 1'b0, valid: 1'b1};
`ifdef AXI_TLB_LOOKUP_MULTIHIT_EN
        lookup(0, 32'h0001_0ABC, "prio_rd", mk(0, 48'h0));
`else
        lookup(0, 32'h0001_0ABC, "prio_rd", mk(1, 48'h0000_0008_0ABC));
`endif
        ents[1] = '0;

        ents[2] = '{first: 20'h21, last: 20'h20, base: 36'h100, read_only: 1'b0, valid: 1'b1};
        lookup(0, 32'h0002_0000, "inv_rd0", mk(0, 48'h0));
        lookup(0, 32'h0002_1000, "inv_rd1", mk(0, 48'h0));
        ents[2] = '0;

        ents[3] = '{first: 20'h100, last: 20'h1FF, base: 36'hF_FFFF_FFFF, read_only: 1'b0, valid: 1'b1};
        lookup(0, 32'h0010_0ABC, "wrap_rd0", mk(1, 48'hFFFF_FFFF_FABC));
        lookup(1, 32'h0010_1ABC, "wrap_wr1", mk(1, 48'h0000_0000_0ABC));
        ents[3] = '0;

        bypass = 1'b1;
        lookup(0, 32'hFFFF_F123, "byp_rd", mk(1, 48'h0000_FFFF_F123));
        lookup(1, 32'h0001_2345, "byp_wr", mk(1, 48'h0000_0001_2345));
        bypass = 1'b0;

        // Backpressure: held result must survive table changes.
        rd_rr = 1'b0; rd_addr = 32'h0001_2345; rd_v = 1'b1;
        @(posedge clk); #1;
        check("bp_vld0", rd_rv, 1);
        check("bp_res0", rd_res, mk(1, 48'h0000_0008_2345));
        rd_addr = 32'h0001_3000;
        for (int c = 0; c < 5; c++) begin
            ents[0].base = 36'($urandom());
            ents[1] = '{first: 20'h0, last: 20'hFFFFF, base: 36'($urandom()), read_only: 1'b0, valid: 1'b1};
            @(posedge clk); #1;
            check("bp_hold_res", rd_res, mk(1, 48'h0000_0008_2345));
            check("bp_hold_vld", rd_rv, 1);
            check("bp_hold_rdy", rd_rdy, 0);
        end
        ents = '0;
        ents[0] = '{first: 20'h10, last: 20'h1F, base: 36'h80, read_only: 1'b0, valid: 1'b1};
        rd_rr = 1'b1; rd_addr = 32'h0001_1000;
        #1 check("bp_rel_rdy", rd_rdy, 1);
        @(posedge clk); #1;
        check("b2b_res0", rd_res, mk(1, 48'h0000_0008_1000));
        rd_addr = 32'h0001_F001;
        @(posedge clk); #1;
        check("b2b_vld1", rd_rv, 1);
        check("b2b_res1", rd_res, mk(1, 48'h0000_0008_F001));
        rd_v = 1'b0;
        @(posedge clk); #1;
        check("b2b_drain", rd_rv, 0);

        // Reset while holding a result.
        rd_rr = 1'b0; rd_addr = 32'h0001_2345; rd_v = 1'b1;
        @(posedge clk); #1;
        rd_v = 1'b0;
        check("mid_full", rd_rv, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", rd_rv, 0);
        check("mid_rst_res", rd_res, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        lookup(0, 32'h0001_2345, "post_rst", mk(1, 48'h0000_0008_2345));

        // Randomized traffic on both pipes against the model.
        ewf = 0; erf = 0; ewr = '0; err = '0;
`ifdef AXI_TLB_LOOKUP_MULTIHIT_EN
        ewm = 0; erm = 0;
`endif
        for (int k = 0; k < 400; k++) begin
            if (k % 8 == 0)
                for (int i = 0; i < NE; i++) begin
                    ents[i].first     = 20'($urandom_range(0, 63));
                    ents[i].last      = 20'($urandom_range(0, 63));
                    ents[i].base      = 36'({$urandom(), $urandom()});
                    ents[i].read_only = 1'($urandom_range(0, 1));
                    ents[i].valid     = ($urandom_range(0, 3) != 0);
                end
            bypass  = ($urandom_range(0, 9) == 0);
            wr_addr = {20'($urandom_range(0, 63)), 12'($urandom())};
            rd_addr = {20'($urandom_range(0, 63)), 12'($urandom())};
            wr_v    = 1'($urandom_range(0, 1));
            rd_v    = 1'($urandom_range(0, 1));
            wr_rr   = ($urandom_range(0, 3) != 0);
            rd_rr   = ($urandom_range(0, 3) != 0);
            #1;
            check("rnd_wr_rdy", wr_rdy, !ewf || wr_rr);
            check("rnd_rd_rdy", rd_rdy, !erf || rd_rr);
            if (wr_v && (!ewf || wr_rr)) begin
                ewf = 1; ewr = ref_lookup(wr_addr, 1, ents, bypass);
`ifdef AXI_TLB_LOOKUP_MULTIHIT_EN
                ewm = (count_hits(wr_addr, 1, ents) > 1) && !bypass;
`endif
            end else if (wr_rr) ewf = 0;
            if (rd_v && (!erf || rd_rr)) begin
                erf = 1; err = ref_lookup(rd_addr, 0, ents, bypass);
`ifdef AXI_TLB_LOOKUP_MULTIHIT_EN
                erm = (count_hits(rd_addr, 0, ents) > 1) && !bypass;
`endif
            end else if (rd_rr) erf = 0;
            @(posedge clk); #1;
            check("rnd_wr_vld", wr_rv, ewf);
            check("rnd_rd_vld", rd_rv, erf);
            if (ewf) check("rnd_wr_res", wr_res, ewr);
            if (erf) check("rnd_rd_res", rd_res, err);
`ifdef AXI_TLB_LOOKUP_MULTIHIT_EN
            check("rnd_wr_mh", wr_mh, ewf && ewm);
            check("rnd_rd_mh", rd_mh, erf && erm);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
